nios2_debug_cmd_sysclk_bridge: RTL

//  System-clock side of the Nios II JTAG debug path, parametrised. Takes the
//  TCK-domain shift register (sr), instruction (ir_in) and the virtual-JTAG

---
 rtl/nios2_debug_cmd_sysclk_bridge.sv | 126 ++++++++++++
 1 files changed

// File: rtl/nios2_debug_cmd_sysclk_bridge.sv
// System-clock side of the Nios II JTAG debug path: synchronises update strobes and queues {ir,sr} commands.
// Optional DEBUG_CMD_TIMESTAMP_EN stores a 16-bit capture timestamp per command.
module nios2_debug_cmd_sysclk_bridge #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACT_BIT     = 37
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SR_W-1:0] sr,
    input  logic [IR_W-1:0] ir_in,
    input  logic            vs_udr,
    input  logic            vs_uir,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [IR_W-1:0] cmd_ir,
    output logic [SR_W-1:0] cmd_jdo,
    output logic            cmd_take_action,
    output logic [15:0]     cmd_ts,
    output logic            uir_pulse,
    output logic            fifo_full,
    output logic            overflow,
    input  logic            overflow_clr
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = AW + 1;
    localparam int GUARD_W = $clog2(SYNC_STAGES + 2);
    localparam int ENT_W   = IR_W + SR_W;

    // Handshake: an entry transfers on any clock edge where cmd_valid & cmd_ready;
    // cmd_* hold steady while cmd_valid & ~cmd_ready.

    logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
    logic                   udr_prev, uir_prev, uir_d;
    logic [GUARD_W-1:0]     guard_cnt;
    logic                   guard_open, udr_rise, uir_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync  <= '0;
            uir_sync  <= '0;
            udr_prev  <= 1'b0;
            uir_prev  <= 1'b0;
            uir_d     <= 1'b0;
            uir_pulse <= 1'b0;
            guard_cnt <= GUARD_W'(SYNC_STAGES + 1);
        end else begin
            udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_prev  <= udr_sync[SYNC_STAGES-1];
            uir_prev  <= uir_sync[SYNC_STAGES-1];
            uir_d     <= uir_rise;
            uir_pulse <= uir_d;
            if (guard_cnt != '0) guard_cnt <= guard_cnt - GUARD_W'(1);
        end
    end

    // The guard hides the edge a strobe held across reset would otherwise produce.
    assign guard_open = (guard_cnt == '0);
    assign udr_rise   = guard_open & udr_sync[SYNC_STAGES-1] & ~udr_prev;
    assign uir_rise   = guard_open & uir_sync[SYNC_STAGES-1] & ~uir_prev;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, count, remain, head_ptr;
    logic             full, pop, push, drop;

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == PTR_W'(FIFO_DEPTH));
    assign fifo_full = full;
    assign pop       = cmd_valid & cmd_ready;
    assign push      = udr_rise & (~full | pop);
    assign drop      = udr_rise & full & ~pop;
    assign remain    = count - PTR_W'(pop);
    assign head_ptr  = rd_ptr + PTR_W'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {ir_in, sr};
    end

    // cmd_* always reflect the head after this edge's pop, never the entry pushed this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            cmd_valid       <= 1'b0;
            cmd_ir          <= '0;
            cmd_jdo         <= '0;
            cmd_take_action <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cmd_valid <= (remain != '0);
            if (remain != '0) begin
                {cmd_ir, cmd_jdo} <= mem[head_ptr[AW-1:0]];
                cmd_take_action   <= mem[head_ptr[AW-1:0]][ACT_BIT];
            end
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

`ifdef DEBUG_CMD_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] ts_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) ts_mem[wr_ptr[AW-1:0]] <= ts_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt <= '0;
            cmd_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (remain != '0) cmd_ts <= ts_mem[head_ptr[AW-1:0]];
        end
    end
`else
    assign cmd_ts = 16'h0;
`endif

endmodule
